load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Sequences core data-memory requests onto the single-port byte-masked word memory (mem_* bus).
//  Handles RV32I access widths: LB/LH/LW/LBU/LHU and SB/SH/SW.
//  Aligns store data and byte mask; waits the memory read latency; extracts and sign/zero-extends load data.
//  Sits between the core's execute stage and the data memory. One request in flight at a time.
// PARAMETERS
//  RDATA_LATENCY  1  cycles from mem_rstrb high to mem_rdata valid (>=1)
// PORTS
//  clk             in   1   sole clock, rising edge
//  reset           in   1   synchronous, active-high
//  req_valid       in   1   core presents a request
//  req_ready       out  1   unit can accept (high only in IDLE)
//  req_we          in   1   1=store, 0=load
//  req_funct3      in   3   RV32I funct3 width/sign code
//  req_addr        in   32  byte address
//  req_wdata       in   32  store data, right-justified
//  rsp_valid       out  1   one-cycle pulse: request complete
//  rsp_rdata       out  32  extended load data (0 for stores/faults)
//  rsp_fault       out  1   misaligned or illegal funct3; qualifies rsp_valid
//  mem_addr        out  32  {addr[31:2],2'b00}
//  mem_rstrb       out  1   read strobe
//  mem_wdata       out  32  lane-replicated store data
//  mem_wmask       out  4   byte write enables
//  mem_rdata       in   32  memory read word
// BEHAVIOUR
//  - Reset: state=IDLE; req_ready=1; rsp_valid=0, rsp_fault=0, rsp_rdata=0; mem_rstrb=0, mem_wmask=0, mem_addr=0, mem_wdata=0.
//  - FSM states: IDLE, ISSUE, WAIT, DONE.
//  - IDLE: req_valid&&req_ready latches we/funct3/addr/wdata.
//    - Faulting request -> DONE with fault=1; no memory access.
//    - Otherwise -> ISSUE.
//  - ISSUE (1 cycle): mem_addr valid.
//    - Load: mem_rstrb=1 -> WAIT, counter=RDATA_LATENCY.
//    - Store: mem_wmask/mem_wdata driven -> DONE.
//  - WAIT: counter decrements; at 0, sample mem_rdata into rsp_rdata -> DONE.
//  - DONE: rsp_valid=1 for exactly one cycle -> IDLE.
//  - Latency (accept edge to rsp_valid): load 2+RDATA_LATENCY cycles; store 2; fault 1.
//  - mem_rstrb and mem_wmask are 0 in every state except ISSUE. Never both nonzero.
//  - Faults:
//    - Half access with addr[0]=1; word access with addr[1:0]!=0.
//    - Load funct3 in {011,110,111}; store funct3 >=011.
//  - Store lanes:
//    - SB: wdata={4{b}}, mask=4'b0001<<addr[1:0].
//    - SH: wdata={2{h}}, mask=addr[1]?1100:0011.
//    - SW: mask=1111.
//  - Load extract: byte lane addr[1:0], half lane addr[1].
//    - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
//  - rsp_rdata holds its value until the next DONE; it is 0 for stores and faults.
//  - req_valid in non-IDLE states is ignored (req_ready=0). No buffering.
//  - Reset in any state: immediate return to IDLE with reset values. A pending mem_rdata is discarded; no rsp_valid is issued.
// STRUCTURE
//  - Shared package: funct3 localparams (F3_B,F3_H,F3_W,F3_BU,F3_HU); state encoding.
//  - Sub-module lsu_load_align: combinational extract + extend (rdata, addr[1:0], funct3 -> 32b). Reused by the core's forwarding path.
// TESTING (memory model: word 0x40=0x8899AABB, RDATA_LATENCY=1)
//  1 LB addr 0x41 -> rstrb one cycle, mem_addr=0x40, rsp_valid 3 cycles after accept, rdata=0xFFFFFFAA, fault=0
//  2 LHU 0x42 -> rdata=0x00008899; LH 0x42 -> 0xFFFF8899; LW 0x40 -> 0x8899AABB
//  3 SB 0x43 wdata=0x12345677 -> wmask=1000, mem_wdata=0x77777777; LW 0x40 then returns 0x7799AABB
//  4 LW 0x42, SH 0x41, load funct3=011 -> rsp_fault=1 one cycle after accept, rstrb/wmask never asserted
//  5 reset asserted during WAIT of LW -> next cycle IDLE, req_ready=1, no rsp_valid; following SW 0x40 completes normally
//  6 req_valid held high, back-to-back LW/SW/LB -> one accept per return to IDLE, responses in order, none dropped

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 width codes,
// FSM state encoding and the request legality check.
package load_store_unit_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } lsu_state_e;

  // Illegal width code or an address not aligned to the access size.
  function automatic logic lsu_is_fault(input logic we, input logic [2:0] f3,
                                        input logic [1:0] addr_lo);
    logic bad_f3;
    logic misaligned;
    if (we) bad_f3 = (f3 > F3_W);
    else    bad_f3 = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    case (f3[1:0])
      2'b01:   misaligned = addr_lo[0];
      2'b10:   misaligned = (addr_lo != 2'b00);
      default: misaligned = 1'b0;
    endcase
    return bad_f3 || misaligned;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load-data extraction: selects the byte/half lane from the
// memory word and sign- or zero-extends it to 32 bits.
module lsu_load_align
  import load_store_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    data = {{16{half_sel[15]}}, half_sel};
      F3_BU:   data = {24'd0, byte_sel};
      F3_HU:   data = {16'd0, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store sequencer between the core execute stage and a
// byte-masked word memory with a fixed read latency.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int RDATA_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault,
  output logic [31:0] mem_addr,
  output logic        mem_rstrb,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic [31:0] mem_rdata
);

  localparam int CNT_W = (RDATA_LATENCY < 1) ? 1 : $clog2(RDATA_LATENCY + 1);

  lsu_state_e       state, state_nxt;
  logic             we_q;
  logic [2:0]       f3_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic             fault_q;
  logic [CNT_W-1:0] cnt_q;
  logic             accept;
  logic             req_fault;
  logic [31:0]      load_data;
  logic [31:0]      store_wdata;
  logic [3:0]       store_mask;

  assign accept    = req_valid && req_ready;
  assign req_fault = lsu_is_fault(req_we, req_funct3, req_addr[1:0]);

  lsu_load_align u_load_align (
    .rdata   (mem_rdata),
    .addr_lo (addr_q[1:0]),
    .funct3  (f3_q),
    .data    (load_data)
  );

  // Store lane replication; only legal store widths ever reach ISSUE.
  always_comb begin
    case (f3_q[1:0])
      2'b00: begin
        store_wdata = {4{wdata_q[7:0]}};
        store_mask  = 4'b0001 << addr_q[1:0];
      end
      2'b01: begin
        store_wdata = {2{wdata_q[15:0]}};
        store_mask  = addr_q[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        store_wdata = wdata_q;
        store_mask  = 4'b1111;
      end
    endcase
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_fault = 1'b0;
    mem_addr  = '0;
    mem_rstrb = 1'b0;
    mem_wdata = '0;
    mem_wmask = '0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = req_fault ? ST_DONE : ST_ISSUE;
      end
      ST_ISSUE: begin
        mem_addr = {addr_q[31:2], 2'b00};
        if (we_q) begin
          mem_wdata = store_wdata;
          mem_wmask = store_mask;
          state_nxt = ST_DONE;
        end else begin
          mem_rstrb = 1'b1;
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == CNT_W'(1)) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        rsp_valid = 1'b1;
        rsp_fault = fault_q;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // The last WAIT cycle is the one in which the read word is valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      fault_q   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        fault_q <= req_fault;
        if (req_fault) rsp_rdata <= '0;
      end
      if (state == ST_ISSUE) begin
        if (we_q) rsp_rdata <= '0;
        else      cnt_q     <= CNT_W'(RDATA_LATENCY);
      end
      if (state == ST_WAIT) begin
        cnt_q <= cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) rsp_rdata <= load_data;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, reset/back-to-back
// sequences and random traffic checked against a byte-array memory model.
module tb_load_store_unit;

  localparam int LAT = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;
  logic [31:0] mem_addr;
  logic        mem_rstrb;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_rdata;
  logic        mem_init;

  int n_chk  = 0;
  int n_fail = 0;
  int rsp_seen = 0;
  int exp_rsp  = 0;
  int overlap  = 0;

  always #5 clk = ~clk;

  load_store_unit #(.RDATA_LATENCY(LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_fault  (rsp_fault),
    .mem_addr   (mem_addr),
    .mem_rstrb  (mem_rstrb),
    .mem_wdata  (mem_wdata),
    .mem_wmask  (mem_wmask),
    .mem_rdata  (mem_rdata)
  );

  function automatic logic [31:0] init_word(input int i);
    logic [31:0] w;
    w = 32'h1357_9BDF ^ (32'(i) * 32'h0102_0304);
    return (i == 16) ? 32'h8899_AABB : w;
  endfunction

  // Word memory seen by the DUT; read data is valid only exactly LAT cycles after the strobe.
  logic [31:0] mem_w [64];
  logic [32:0] rpipe [LAT];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem_w[i] <= init_word(i);
    end else begin
      for (int j = 0; j < 4; j++)
        if (mem_wmask[j]) mem_w[mem_addr[7:2]][8*j +: 8] <= mem_wdata[8*j +: 8];
    end
    rpipe[0] <= {mem_rstrb, mem_w[mem_addr[7:2]]};
    for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
  end

  assign mem_rdata = rpipe[LAT-1][32] ? rpipe[LAT-1][31:0] : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (!reset && rsp_valid) rsp_seen++;
    if (mem_rstrb && (mem_wmask != 4'd0)) overlap++;
  end

  // Reference model: byte-addressed memory, access size and legality from the ISA rules.
  logic [7:0] ref_mem [256];

  function automatic void ref_access(input logic we, input logic [2:0] f3,
                                     input logic [31:0] addr, input logic [31:0] wd,
                                     output logic flt, output logic [31:0] rd,
                                     output logic [3:0] mask);
    int size;
    int a;
    logic sgn;
    logic legal;
    logic [31:0] v;
    legal = 1'b1;
    sgn   = 1'b0;
    size  = 4;
    case (f3)
      3'd0: begin size = 1; sgn = 1'b1; end
      3'd1: begin size = 2; sgn = 1'b1; end
      3'd2: size = 4;
      3'd4: size = 1;
      3'd5: size = 2;
      default: legal = 1'b0;
    endcase
    if (we && f3 > 3'd2) legal = 1'b0;
    a    = int'(addr[7:0]);
    flt  = !legal || (a % size != 0);
    rd   = '0;
    mask = '0;
    if (flt) return;
    for (int i = 0; i < size; i++) mask[(a % 4) + i] = 1'b1;
    if (we) begin
      for (int i = 0; i < size; i++) ref_mem[a + i] = wd[8*i +: 8];
    end else begin
      v = '0;
      for (int i = 0; i < size; i++) v[8*i +: 8] = ref_mem[a + i];
      if (sgn && size < 4 && v[8*size-1])
        for (int k = 8*size; k < 32; k++) v[k] = 1'b1;
      rd = v;
    end
  endfunction

  typedef struct {
    int          lat;
    int          nwait;
    logic        flt;
    logic [31:0] rd;
    int          nstrb;
    int          nwm;
    logic [31:0] saddr;
    logic [3:0]  smask;
    logic [31:0] swd;
  } obs_t;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        flt;
    logic [31:0] rd;
    logic [3:0]  wm;
    logic [31:0] mwd;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input bit hold, output obs_t o);
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    o.nwait = 0;
    while (!req_ready && o.nwait < 50) begin
      @(negedge clk);
      o.nwait++;
    end
    @(posedge clk);
    #1;
    if (!hold) req_valid = 1'b0;
    exp_rsp++;
    o.lat = 0; o.nstrb = 0; o.nwm = 0; o.flt = 1'b0; o.rd = '0;
    o.saddr = '0; o.smask = '0; o.swd = '0;
    while (o.lat < 30) begin
      @(negedge clk);
      o.lat++;
      if (mem_rstrb) begin
        o.nstrb++;
        o.saddr = mem_addr;
      end
      if (mem_wmask != 4'd0) begin
        o.nwm++;
        o.saddr = mem_addr;
        o.smask = mem_wmask;
        o.swd   = mem_wdata;
      end
      if (rsp_valid) begin
        o.flt = rsp_fault;
        o.rd  = rsp_rdata;
        break;
      end
    end
  endtask

  task automatic check_txn(input string nm, input logic we, input logic [31:0] addr,
                           input logic eflt, input logic [31:0] erd, input logic [3:0] emask,
                           input obs_t o);
    chk({nm, ".latency"}, o.lat, eflt ? 1 : (we ? 2 : 2 + LAT));
    chk({nm, ".fault"}, {31'd0, o.flt}, {31'd0, eflt});
    chk({nm, ".rdata"}, o.rd, erd);
    chk({nm, ".rstrb_cycles"}, o.nstrb, (!we && !eflt) ? 1 : 0);
    chk({nm, ".wmask_cycles"}, o.nwm, (we && !eflt) ? 1 : 0);
    if (we && !eflt) chk({nm, ".wmask"}, {28'd0, o.smask}, {28'd0, emask});
    if (!eflt) chk({nm, ".mem_addr"}, o.saddr, addr & 32'hFFFF_FFFC);
  endtask

  vec_t tbl [13];

  initial begin
    obs_t        o;
    logic        mflt;
    logic [31:0] mrd;
    logic [3:0]  mmask;
    logic        r_we;
    logic [2:0]  r_f3;
    logic [31:0] r_addr;
    logic [31:0] r_wd;
    int          bad;

    //          we    f3     addr          wdata         flt   rdata         wmask    mem_wdata
    tbl[0]  = '{1'b0, 3'd0, 32'h41, 32'h0,          1'b0, 32'hFFFF_FFAA, 4'b0000, 32'h0};
    tbl[1]  = '{1'b0, 3'd5, 32'h42, 32'h0,          1'b0, 32'h0000_8899, 4'b0000, 32'h0};
    tbl[2]  = '{1'b0, 3'd1, 32'h42, 32'h0,          1'b0, 32'hFFFF_8899, 4'b0000, 32'h0};
    tbl[3]  = '{1'b0, 3'd2, 32'h40, 32'h0,          1'b0, 32'h8899_AABB, 4'b0000, 32'h0};
    tbl[4]  = '{1'b1, 3'd0, 32'h43, 32'h1234_5677,  1'b0, 32'h0,         4'b1000, 32'h7777_7777};
    tbl[5]  = '{1'b0, 3'd2, 32'h40, 32'h0,          1'b0, 32'h7799_AABB, 4'b0000, 32'h0};
    tbl[6]  = '{1'b0, 3'd2, 32'h42, 32'h0,          1'b1, 32'h0,         4'b0000, 32'h0};
    tbl[7]  = '{1'b1, 3'd1, 32'h41, 32'h5555_5555,  1'b1, 32'h0,         4'b0000, 32'h0};
    tbl[8]  = '{1'b0, 3'd3, 32'h40, 32'h0,          1'b1, 32'h0,         4'b0000, 32'h0};
    tbl[9]  = '{1'b1, 3'd1, 32'h42, 32'h0000_BEEF,  1'b0, 32'h0,         4'b1100, 32'hBEEF_BEEF};
    tbl[10] = '{1'b0, 3'd4, 32'h43, 32'h0,          1'b0, 32'h0000_00BE, 4'b0000, 32'h0};
    tbl[11] = '{1'b1, 3'd3, 32'h40, 32'h1111_1111,  1'b1, 32'h0,         4'b0000, 32'h0};
    tbl[12] = '{1'b0, 3'd0, 32'h42, 32'h0,          1'b0, 32'hFFFF_FFEF, 4'b0000, 32'h0};

    for (int i = 0; i < 64; i++) begin
      logic [31:0] w;
      w = init_word(i);
      for (int b = 0; b < 4; b++) ref_mem[4*i + b] = w[8*b +: 8];
    end

    reset = 1'b1; mem_init = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset.req_ready", {31'd0, req_ready}, 32'd1);
    chk("reset.rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset.rsp_fault", {31'd0, rsp_fault}, 32'd0);
    chk("reset.rsp_rdata", rsp_rdata, 32'd0);
    chk("reset.mem_rstrb", {31'd0, mem_rstrb}, 32'd0);
    chk("reset.mem_wmask", {28'd0, mem_wmask}, 32'd0);
    chk("reset.mem_addr", mem_addr, 32'd0);
    chk("reset.mem_wdata", mem_wdata, 32'd0);
    reset = 1'b0; mem_init = 1'b0;

    for (int i = 0; i < 13; i++) begin
      ref_access(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wd, mflt, mrd, mmask);
      run_txn(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wd, 1'b0, o);
      check_txn($sformatf("vec%0d", i), tbl[i].we, tbl[i].addr, tbl[i].flt, tbl[i].rd,
                tbl[i].wm, o);
      if (tbl[i].we && !tbl[i].flt)
        chk($sformatf("vec%0d.mem_wdata", i), o.swd, tbl[i].mwd);
    end

    @(negedge clk);
    chk("hold.rsp_rdata", rsp_rdata, 32'hFFFF_FFEF);
    chk("hold.rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("hold.req_ready", {31'd0, req_ready}, 32'd1);

    // Reset while a load waits on memory: the load is dropped silently.
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h40; req_wdata = '0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("rst_wait.issue_rstrb", {31'd0, mem_rstrb}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_wait.req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_wait.rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_wait.rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_wait.mem_rstrb", {31'd0, mem_rstrb}, 32'd0);
    reset = 1'b0;
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid) bad++;
    end
    chk("rst_wait.no_rsp", bad, 0);
    ref_access(1'b1, 3'd2, 32'h40, 32'hCAFE_F00D, mflt, mrd, mmask);
    run_txn(1'b1, 3'd2, 32'h40, 32'hCAFE_F00D, 1'b0, o);
    check_txn("post_rst_sw", 1'b1, 32'h40, mflt, mrd, mmask, o);
    chk("post_rst_sw.mem_wdata", o.swd, 32'hCAFE_F00D);
    ref_access(1'b0, 3'd2, 32'h40, 32'h0, mflt, mrd, mmask);
    run_txn(1'b0, 3'd2, 32'h40, 32'h0, 1'b0, o);
    check_txn("post_rst_lw", 1'b0, 32'h40, mflt, mrd, mmask, o);

    // Back-to-back with req_valid held high throughout.
    ref_access(1'b0, 3'd2, 32'h40, 32'h0, mflt, mrd, mmask);
    run_txn(1'b0, 3'd2, 32'h40, 32'h0, 1'b1, o);
    check_txn("b2b_lw", 1'b0, 32'h40, mflt, mrd, mmask, o);
    ref_access(1'b1, 3'd2, 32'h44, 32'hA1B2_C3D4, mflt, mrd, mmask);
    run_txn(1'b1, 3'd2, 32'h44, 32'hA1B2_C3D4, 1'b1, o);
    check_txn("b2b_sw", 1'b1, 32'h44, mflt, mrd, mmask, o);
    chk("b2b_sw.accept_wait", o.nwait, 0);
    ref_access(1'b0, 3'd0, 32'h45, 32'h0, mflt, mrd, mmask);
    run_txn(1'b0, 3'd0, 32'h45, 32'h0, 1'b1, o);
    req_valid = 1'b0;
    check_txn("b2b_lb", 1'b0, 32'h45, mflt, mrd, mmask, o);
    chk("b2b_lb.accept_wait", o.nwait, 0);

    for (int i = 0; i < 150; i++) begin
      r_we   = 1'($urandom_range(0, 1));
      r_f3   = 3'($urandom_range(0, 7));
      r_addr = 32'($urandom_range(0, 255));
      r_wd   = $urandom;
      ref_access(r_we, r_f3, r_addr, r_wd, mflt, mrd, mmask);
      run_txn(r_we, r_f3, r_addr, r_wd, 1'b0, o);
      check_txn($sformatf("rnd%0d", i), r_we, r_addr, mflt, mrd, mmask, o);
    end

    repeat (3) @(negedge clk);
    chk("rsp_count", rsp_seen, exp_rsp);
    chk("rstrb_wmask_overlap", overlap, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
